// File: rtl/dds_pkg.sv
// Shared definitions for the DDS tone generator and its sweep sequencer.
package dds_pkg;

  localparam int DDS_PW = 32;
  localparam int DDS_CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_LAST  = 2'd3
  } sweep_state_e;

  typedef struct packed {
    logic [DDS_PW-1:0] f_start;
    logic [DDS_PW-1:0] f_stop;
    logic [DDS_PW-1:0] f_step;
    logic [DDS_CW-1:0] dwell;
    logic [DDS_PW-1:0] phase;
    logic              repeat_en;
  } dds_sweep_cfg_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; a dwell of zero behaves as one cycle.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] dwell,
  input  logic          tick,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (dwell == '0) ? CW'(1) : dwell;
    end else if (tick && (cnt_q > CW'(1))) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency-sweep sequencer driving the control inputs of one DDS.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PW = DDS_PW,
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_f_start,
  input  logic [PW-1:0] cfg_f_stop,
  input  logic [PW-1:0] cfg_f_step,
  input  logic [CW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic          cfg_repeat,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          dds_en,
  output logic          dds_clr,
  output logic [PW-1:0] dds_freq,
  output logic [PW-1:0] dds_phase
);

  sweep_state_e   state_q, state_d;
  dds_sweep_cfg_t cfg_q, cfg_d;
  logic           loaded_q, loaded_d;
  logic           cfg_ready_q, cfg_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           en_q, en_d;
  logic           clr_q, clr_d;
  logic [PW-1:0]  freq_q, freq_d;
  logic [PW-1:0]  phase_q, phase_d;

  logic           cfg_hs;
  logic [PW:0]    f_next;
  logic           tmr_load, tmr_tick, tmr_last;

  dds_dwell_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .dwell (cfg_q.dwell),
    .tick  (tmr_tick),
    .last  (tmr_last)
  );

  // The extra top bit catches a carry out so the final word clamps instead of wrapping.
  assign f_next = {1'b0, freq_q} + {1'b0, cfg_q.f_step};
  assign cfg_hs = cfg_ready_q && cfg_valid;

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    loaded_d = loaded_q;
    freq_d   = freq_q;
    en_d     = 1'b0;
    clr_d    = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;

    if (cfg_hs) begin
      cfg_d.f_start   = cfg_f_start;
      cfg_d.f_stop    = cfg_f_stop;
      cfg_d.f_step    = cfg_f_step;
      cfg_d.dwell     = cfg_dwell;
      cfg_d.phase     = cfg_phase;
      cfg_d.repeat_en = cfg_repeat;
      loaded_d        = 1'b1;
    end else begin
      cfg_d = cfg_q;
    end

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && loaded_d) begin
            state_d = ST_LOAD;
            clr_d   = 1'b1;
            freq_d  = cfg_d.f_start;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          tmr_load = 1'b1;
          en_d     = 1'b1;
          if (cfg_q.f_start >= cfg_q.f_stop) begin
            state_d = ST_LAST;
            freq_d  = cfg_q.f_stop;
          end else begin
            state_d = ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          en_d = 1'b1;
          if (tmr_last) begin
            tmr_load = 1'b1;
            if (f_next >= {1'b0, cfg_q.f_stop}) begin
              state_d = ST_LAST;
              freq_d  = cfg_q.f_stop;
            end else begin
              freq_d  = f_next[PW-1:0];
            end
          end else begin
            tmr_tick = 1'b1;
          end
        end
        ST_LAST: begin
          if (tmr_last) begin
            done_d = 1'b1;
            if (cfg_q.repeat_en) begin
              state_d = ST_LOAD;
              clr_d   = 1'b1;
              freq_d  = cfg_q.f_start;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            en_d     = 1'b1;
            tmr_tick = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d      = (state_d != ST_IDLE);
    cfg_ready_d = (state_d == ST_IDLE);
    phase_d     = cfg_d.phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      loaded_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      freq_q      <= '0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      loaded_q    <= loaded_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dds_en    = en_q;
  assign dds_clr   = clr_q;
  assign dds_freq  = freq_q;
  assign dds_phase = phase_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl against a per-cycle trace model built from the sweep rules.
module tb_dds_sweep_ctrl;

  localparam int PW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_f_start, cfg_f_stop, cfg_f_step, cfg_phase;
  logic [CW-1:0] cfg_dwell;
  logic          cfg_repeat;
  logic          start, abort;
  logic          busy, done, dds_en, dds_clr;
  logic [PW-1:0] dds_freq, dds_phase;

  dds_sweep_ctrl #(.PW(PW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_repeat(cfg_repeat),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .dds_en(dds_en), .dds_clr(dds_clr),
    .dds_freq(dds_freq), .dds_phase(dds_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fs, fe, st, ph;
    logic [15:0] dw;
    bit          rp;
  } desc_t;

  typedef struct {
    bit          en, clr, busy, done;
    logic [31:0] freq;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output trace from the LOAD cycle on, for a number of passes.
  function automatic void build(input desc_t d, input int passes);
    logic [31:0] words[$];
    longint      w, nx;
    int          hold;
    rec_t        r;
    hold = (d.dw == 16'd0) ? 1 : int'(d.dw);
    exp_q.delete();
    if (d.fs >= d.fe) begin
      words.push_back(d.fe);
    end else begin
      w = d.fs;
      while (words.size() < 64) begin
        words.push_back(w[31:0]);
        nx = w + longint'(d.st);
        if (nx >= longint'(d.fe)) begin
          words.push_back(d.fe);
          break;
        end
        w = nx;
      end
    end
    for (int p = 0; p < passes; p++) begin
      r = '{en: 1'b0, clr: 1'b1, busy: 1'b1, done: (p > 0), freq: d.fs};
      exp_q.push_back(r);
      foreach (words[i]) begin
        for (int k = 0; k < hold; k++) begin
          r = '{en: 1'b1, clr: 1'b0, busy: 1'b1, done: 1'b0, freq: words[i]};
          exp_q.push_back(r);
        end
      end
    end
    if (!d.rp) begin
      r = '{en: 1'b0, clr: 1'b0, busy: 1'b0, done: 1'b1, freq: d.fe};
      exp_q.push_back(r);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input desc_t d);
    cfg_f_start = d.fs; cfg_f_stop = d.fe; cfg_f_step = d.st;
    cfg_dwell = d.dw; cfg_phase = d.ph; cfg_repeat = d.rp;
    cfg_valid = 1'b1;
  endtask

  task automatic load_only(input desc_t d);
    offer(d);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic launch(input desc_t d, input bit with_cfg);
    if (with_cfg) offer(d);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic check_rec(input string tag, input rec_t r, input logic [31:0] ph);
    chk({tag, ".en"},    64'(dds_en),    64'(r.en));
    chk({tag, ".clr"},   64'(dds_clr),   64'(r.clr));
    chk({tag, ".busy"},  64'(busy),      64'(r.busy));
    chk({tag, ".done"},  64'(done),      64'(r.done));
    chk({tag, ".ready"}, 64'(cfg_ready), 64'(!r.busy));
    chk({tag, ".freq"},  64'(dds_freq),  64'(r.freq));
    chk({tag, ".phase"}, 64'(dds_phase), 64'(ph));
  endtask

  task automatic run_trace(input string tag, input logic [31:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      check_rec($sformatf("%s[%0d]", tag, i), exp_q[i], ph);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ready"}, 64'(cfg_ready), 64'd1);
    chk({tag, ".busy"},  64'(busy),      64'd0);
    chk({tag, ".done"},  64'(done),      64'd0);
    chk({tag, ".en"},    64'(dds_en),    64'd0);
    chk({tag, ".clr"},   64'(dds_clr),   64'd0);
    chk({tag, ".freq"},  64'(dds_freq),  64'd0);
    chk({tag, ".phase"}, 64'(dds_phase), 64'd0);
  endtask

  desc_t d1, d2, d3, dr;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0; cfg_dwell = '0;
    cfg_phase = '0; cfg_repeat = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check_reset_vals("rst");

    // start before any descriptor is ignored
    start = 1'b1; step(); start = 1'b0;
    chk("nocfg.busy", 64'(busy), 64'd0);
    chk("nocfg.clr",  64'(dds_clr), 64'd0);

    d1 = '{fs: 32'd100, fe: 32'd400, st: 32'd100, ph: 32'h1234_5678, dw: 16'd3, rp: 1'b0};
    load_only(d1);
    launch(d1, 1'b0);
    build(d1, 1);
    run_trace("plan", d1.ph, exp_q.size());

    d2 = '{fs: 32'hFFFF_FF00, fe: 32'hFFFF_FFFF, st: 32'h80, ph: 32'hA5A5_0001, dw: 16'd2, rp: 1'b0};
    launch(d2, 1'b1);
    build(d2, 1);
    run_trace("ovf", d2.ph, exp_q.size());

    d2 = '{fs: 32'd5, fe: 32'd5, st: 32'd1, ph: 32'd7, dw: 16'd0, rp: 1'b0};
    launch(d2, 1'b1);
    build(d2, 1);
    run_trace("dw0", d2.ph, exp_q.size());

    // descriptor offered mid-sweep waits for IDLE, shadow untouched meanwhile
    d2 = '{fs: 32'd10, fe: 32'd25, st: 32'd7, ph: 32'hBEEF_0002, dw: 16'd1, rp: 1'b0};
    launch(d1, 1'b1);
    build(d1, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      check_rec($sformatf("hold[%0d]", i), exp_q[i], d1.ph);
      if (i == 0) offer(d2);
    end
    step();
    cfg_valid = 1'b0;
    chk("hold.newph", 64'(dds_phase), 64'(d2.ph));
    launch(d2, 1'b0);
    build(d2, 1);
    run_trace("hold2", d2.ph, exp_q.size());

    // repeat: three passes then abort mid-step
    d3 = '{fs: 32'd1000, fe: 32'd1300, st: 32'd100, ph: 32'h0F0F_0F0F, dw: 16'd2, rp: 1'b1};
    launch(d3, 1'b1);
    build(d3, 3);
    run_trace("rpt", d3.ph, exp_q.size() - 3);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort.en",   64'(dds_en), 64'd0);
    chk("abort.busy", 64'(busy),   64'd0);
    chk("abort.done", 64'(done),   64'd0);
    chk("abort.ready", 64'(cfg_ready), 64'd1);
    step();
    chk("abort.done2", 64'(done), 64'd0);

    // abort and start together: abort wins
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("abst.busy", 64'(busy), 64'd0);
    chk("abst.clr",  64'(dds_clr), 64'd0);

    // randomized descriptors
    for (int n = 0; n < 25; n++) begin
      longint t;
      int     k;
      bit     wc;
      dr.fs = $urandom;
      dr.st = $urandom_range(1, 1 << 20);
      k     = $urandom_range(0, 5);
      t     = longint'(dr.fs) + longint'(dr.st) * k + longint'($urandom_range(0, dr.st));
      if (t > 64'sh0_FFFF_FFFF) dr.fe = $urandom;
      else dr.fe = t[31:0];
      if ($urandom_range(0, 7) == 0) dr.fe = dr.fs - $urandom_range(0, 3);
      dr.dw = 16'($urandom_range(0, 4));
      dr.ph = $urandom;
      dr.rp = 1'b0;
      wc = $urandom_range(0, 1);
      if (!wc) load_only(dr);
      launch(dr, wc);
      build(dr, 1);
      run_trace($sformatf("rnd%0d", n), dr.ph, exp_q.size());
    end

    // reset during the first scenario at cycle 6
    launch(d1, 1'b1);
    build(d1, 1);
    run_trace("rmid", d1.ph, 6);
    rst = 1'b1; step(); rst = 1'b0;
    check_reset_vals("rmid.rst");
    start = 1'b1; step(); start = 1'b0;
    chk("rmid.busy", 64'(busy), 64'd0);
    chk("rmid.clr",  64'(dds_clr), 64'd0);
    step();
    chk("rmid.busy2", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
